// File: rtl/display_pkg.sv
// Shared types for the display row shifter: FSM state encoding and a small width helper.
package display_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FILL = 3'd1,
    ST_LOW  = 3'd2,
    ST_HIGH = 3'd3,
    ST_DONE = 3'd4
  } row_shifter_state_t;

  // Width of a counter spanning 0..n-1, never less than one bit.
  function automatic int unsigned width_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/display_plane_select.sv
// Bit-plane selector: picks bit [plane] of every colour component and registers it
// on capture; planes beyond the component width read as zero.
module display_plane_select #(
  parameter int CHAINS   = 2,
  parameter int BITWIDTH = 8,
  parameter int PLANE_W  = $clog2(BITWIDTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_capture,
  input  logic [PLANE_W-1:0]           i_plane,
  input  logic [CHAINS*3*BITWIDTH-1:0] i_data,
  output logic [CHAINS*3-1:0]          o_rgb
);

  localparam int NCOMP = CHAINS * 3;

  logic             w_plane_ok;
  logic [NCOMP-1:0] w_sel;
  logic [NCOMP-1:0] r_rgb;

  assign w_plane_ok = (int'(i_plane) < BITWIDTH);

  // Component n occupies i_data[n*BITWIDTH +: BITWIDTH]; chain-major, R,G,B within a chain.
  for (genvar g = 0; g < NCOMP; g++) begin : g_comp
    logic [BITWIDTH-1:0] w_comp;
    assign w_comp   = i_data[g*BITWIDTH +: BITWIDTH];
    assign w_sel[g] = w_plane_ok & w_comp[i_plane];
  end

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rgb <= '0;
    end else if (i_capture) begin
      r_rgb <= w_sel;
    end
  end

  assign o_rgb = r_rgb;

endmodule

// File: rtl/display_row_shifter.sv
// LED panel row shifter: fills the fetch pipeline, then emits COLUMNS oclk pulses with
// one selected bit-plane per component. Optional macro: DISPLAY_ROW_SHIFTER_ABORT_EN.
module display_row_shifter
  import display_pkg::*;
#(
  parameter int PIPE_LENGTH = 2,
  parameter int COLUMNS     = 32,
  parameter int BITWIDTH    = 8,
  parameter int CHAINS      = 2,
  parameter int CLK_DIV     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load,
`ifdef DISPLAY_ROW_SHIFTER_ABORT_EN
  input  logic                         abort,
`endif
  input  logic [$clog2(BITWIDTH)-1:0]  plane,
  input  logic [CHAINS*3*BITWIDTH-1:0] data_in,
  output logic [$clog2(COLUMNS)-1:0]   column,
  output logic                         pipe,
  output logic                         oclk,
  output logic [CHAINS*3-1:0]          rgb,
  output logic                         busy,
  output logic                         complete
);

  localparam int COL_W   = $clog2(COLUMNS);
  localparam int PLANE_W = $clog2(BITWIDTH);
  localparam int PH_MAX  = (PIPE_LENGTH > CLK_DIV) ? PIPE_LENGTH : CLK_DIV;
  localparam int PH_W    = width_of(PH_MAX);

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(COLUMNS - 1);
  localparam logic [PH_W-1:0]  FILL_LAST = PH_W'(PIPE_LENGTH - 1);
  localparam logic [PH_W-1:0]  DIV_LAST  = PH_W'(CLK_DIV - 1);

  row_shifter_state_t r_state, w_next_state;

  logic [PH_W-1:0]    r_phase;
  logic [COL_W-1:0]   r_pair;
  logic [COL_W-1:0]   r_column;
  logic [PLANE_W-1:0] r_plane;

  logic w_abort;
  logic w_pipe, w_oclk, w_busy, w_complete;
  logic w_next_active;
  logic w_capture;

`ifdef DISPLAY_ROW_SHIFTER_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_pipe       = 1'b0;
    w_oclk       = 1'b0;
    w_busy       = 1'b0;
    w_complete   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (load) w_next_state = ST_FILL;
      end
      ST_FILL: begin
        w_pipe = 1'b1;
        w_busy = 1'b1;
        if (r_phase == FILL_LAST) w_next_state = ST_LOW;
      end
      ST_LOW: begin
        w_busy = 1'b1;
        if (r_phase == DIV_LAST) w_next_state = ST_HIGH;
      end
      ST_HIGH: begin
        w_busy = 1'b1;
        w_oclk = 1'b1;
        w_pipe = (r_phase == '0);
        if (r_phase == DIV_LAST) begin
          w_next_state = (r_pair == COL_LAST) ? ST_DONE : ST_LOW;
        end
      end
      ST_DONE: begin
        w_complete   = 1'b1;
        w_next_state = load ? ST_FILL : ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
    if (w_abort) w_next_state = ST_IDLE;
  end

  assign w_next_active = (w_next_state == ST_FILL) || (w_next_state == ST_LOW) ||
                         (w_next_state == ST_HIGH);
  assign w_capture     = (w_next_state == ST_LOW) && (r_state != ST_LOW);

  // r_phase times the current state; r_pair counts completed LOW/HIGH pairs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_phase  <= '0;
      r_pair   <= '0;
      r_column <= '0;
      r_plane  <= '0;
    end else begin
      if (w_next_state != r_state || r_state == ST_IDLE) begin
        r_phase <= '0;
      end else begin
        r_phase <= r_phase + 1'b1;
      end

      if (!w_next_active || w_next_state == ST_FILL) begin
        r_pair <= '0;
      end else if (r_state == ST_HIGH && w_next_state == ST_LOW) begin
        r_pair <= r_pair + 1'b1;
      end

      if (!w_next_active) begin
        r_column <= '0;
      end else if (w_pipe && r_column != COL_LAST) begin
        r_column <= r_column + 1'b1;
      end

      if (w_next_state == ST_FILL && r_state != ST_FILL) begin
        r_plane <= plane;
      end
    end
  end

  display_plane_select #(
    .CHAINS  (CHAINS),
    .BITWIDTH(BITWIDTH),
    .PLANE_W (PLANE_W)
  ) u_plane_select (
    .clk      (clk),
    .rst      (rst),
    .i_capture(w_capture),
    .i_plane  (r_plane),
    .i_data   (data_in),
    .o_rgb    (rgb)
  );

  assign column   = r_column;
  assign pipe     = w_pipe;
  assign oclk     = w_oclk;
  assign busy     = w_busy;
  assign complete = w_complete;

endmodule

// File: tb/tb_display_row_shifter.sv
// Self-checking bench for display_row_shifter: a default instance and a CLK_DIV=3,
// COLUMNS=4 instance, checked by vector tables and a cycle-list reference model.
module tb_display_row_shifter;

  localparam int A_P = 2, A_C = 32, A_BW = 8, A_CH = 2, A_D = 1;
  localparam int B_P = 3, B_C = 4,  B_BW = 6, B_CH = 1, B_D = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_a = 1'b0, load_b = 1'b0;
  logic [2:0]  plane_a = '0, plane_b = '0;
  logic [47:0] mem_a [A_C];
  logic [17:0] mem_b [B_C];
  logic [47:0] data_a;
  logic [17:0] data_b;
  logic [4:0]  col_a;
  logic [1:0]  col_b;
  logic        pipe_a, oclk_a, busy_a, comp_a;
  logic        pipe_b, oclk_b, busy_b, comp_b;
  logic [5:0]  rgb_a;
  logic [2:0]  rgb_b;
`ifdef DISPLAY_ROW_SHIFTER_ABORT_EN
  logic        abort_a = 1'b0, abort_b = 1'b0;
`endif

  // The fetch source is a plain column-addressed memory.
  assign data_a = mem_a[col_a];
  assign data_b = mem_b[col_b];

  always #5 clk = ~clk;

  display_row_shifter #(
    .PIPE_LENGTH(A_P), .COLUMNS(A_C), .BITWIDTH(A_BW), .CHAINS(A_CH), .CLK_DIV(A_D)
  ) u_dut_a (
    .clk(clk), .rst(rst), .load(load_a),
`ifdef DISPLAY_ROW_SHIFTER_ABORT_EN
    .abort(abort_a),
`endif
    .plane(plane_a), .data_in(data_a), .column(col_a), .pipe(pipe_a),
    .oclk(oclk_a), .rgb(rgb_a), .busy(busy_a), .complete(comp_a)
  );

  display_row_shifter #(
    .PIPE_LENGTH(B_P), .COLUMNS(B_C), .BITWIDTH(B_BW), .CHAINS(B_CH), .CLK_DIV(B_D)
  ) u_dut_b (
    .clk(clk), .rst(rst), .load(load_b),
`ifdef DISPLAY_ROW_SHIFTER_ABORT_EN
    .abort(abort_b),
`endif
    .plane(plane_b), .data_in(data_b), .column(col_b), .pipe(pipe_b),
    .oclk(oclk_b), .rgb(rgb_b), .busy(busy_b), .complete(comp_b)
  );

  typedef struct packed {
    logic       pipe;
    logic       oclk;
    logic       busy;
    logic       complete;
    logic [7:0] column;
    logic [7:0] rgb;
  } obs_t;

  typedef struct {
    bit pipe, oclk, busy, complete, low_entry;
    int column;
  } step_t;

  typedef struct {
    int   plane;
    int   t;
    obs_t exp;
  } vec_t;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_rgb [2];
  step_t      row_q [$];
  obs_t       log_a [2][70];
  vec_t       vecs [13];

  function automatic obs_t mk(bit p, bit o, bit b, bit c, int col, logic [7:0] r);
    obs_t x;
    x.pipe = p; x.oclk = o; x.busy = b; x.complete = c;
    x.column = 8'(col); x.rgb = r;
    return x;
  endfunction

  function automatic obs_t observe(int sel);
    if (sel == 0) return mk(pipe_a, oclk_a, busy_a, comp_a, int'(col_a), 8'(rgb_a));
    return mk(pipe_b, oclk_b, busy_b, comp_b, int'(col_b), 8'(rgb_b));
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("pipe=%0b oclk=%0b busy=%0b complete=%0b column=%0d rgb=%h",
                     o.pipe, o.oclk, o.busy, o.complete, o.column, o.rgb);
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %s, expected %s", name, fmt(got), fmt(exp));
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Selected-plane bits of the pixel stored at column k; planes past the width give zero.
  function automatic logic [7:0] pixel_bits(int sel, int k, int pl);
    logic [7:0] r = '0;
    if (sel == 0) begin
      if (pl < A_BW) for (int n = 0; n < A_CH*3; n++) r[n] = mem_a[k][n*A_BW + pl];
    end else begin
      if (pl < B_BW) for (int n = 0; n < B_CH*3; n++) r[n] = mem_b[k][n*B_BW + pl];
    end
    return r;
  endfunction

  // Expected per-cycle behaviour of one row, derived from phase lengths and pipe-pulse count.
  function automatic void build_row(int sel);
    int p = (sel == 0) ? A_P : B_P;
    int c = (sel == 0) ? A_C : B_C;
    int d = (sel == 0) ? A_D : B_D;
    int pulses = 0;
    step_t s;
    row_q.delete();
    for (int i = 0; i < p; i++) begin
      s = '{pipe: 1, oclk: 0, busy: 1, complete: 0, low_entry: 0,
            column: (pulses < c-1) ? pulses : c-1};
      row_q.push_back(s);
      pulses++;
    end
    for (int j = 0; j < c; j++) begin
      for (int k = 0; k < d; k++) begin
        s = '{pipe: 0, oclk: 0, busy: 1, complete: 0, low_entry: (k == 0),
              column: (pulses < c-1) ? pulses : c-1};
        row_q.push_back(s);
      end
      for (int k = 0; k < d; k++) begin
        s = '{pipe: (k == 0), oclk: 1, busy: 1, complete: 0, low_entry: 0,
              column: (pulses < c-1) ? pulses : c-1};
        row_q.push_back(s);
        if (k == 0) pulses++;
      end
    end
    s = '{pipe: 0, oclk: 0, busy: 0, complete: 1, low_entry: 0, column: 0};
    row_q.push_back(s);
  endfunction

  task automatic drive(input int sel, input bit ld, input int pl);
    if (sel == 0) begin
      load_a = ld; plane_a = 3'(pl);
    end else begin
      load_b = ld; plane_b = 3'(pl);
    end
  endtask

  task automatic randomize_mem(input int sel);
    if (sel == 0) for (int k = 0; k < A_C; k++) mem_a[k] = {16'($urandom), $urandom};
    else          for (int k = 0; k < B_C; k++) mem_b[k] = 18'($urandom);
  endtask

  // Runs one row from a negedge; started=1 means the load edge already happened.
  task automatic run_row(input int sel, input int pl, input bit started, input bit chain,
                         input int next_pl, input bit noise, input string tag);
    int   prev_col = 0;
    obs_t e;
    if (!started) begin
      drive(sel, 1'b1, pl);
      @(negedge clk);
    end
    build_row(sel);
    foreach (row_q[i]) begin
      if (row_q[i].low_entry) exp_rgb[sel] = pixel_bits(sel, prev_col, pl);
      e = mk(row_q[i].pipe, row_q[i].oclk, row_q[i].busy, row_q[i].complete,
             row_q[i].column, exp_rgb[sel]);
      check($sformatf("%s t=%0d", tag, i + 1), observe(sel), e);
      prev_col = row_q[i].column;
      if (row_q[i].complete) drive(sel, chain, chain ? next_pl : int'($urandom_range(0, 7)));
      else drive(sel, noise ? 1'($urandom_range(0, 1)) : 1'b0, int'($urandom_range(0, 7)));
      @(negedge clk);
    end
    if (!chain) check($sformatf("%s idle", tag), observe(sel), mk(0, 0, 0, 0, 0, exp_rgb[sel]));
  endtask

  task automatic log_row_a(input int pl, input int slot);
    drive(0, 1'b1, pl);
    @(negedge clk);
    for (int t = 1; t <= 68; t++) begin
      log_a[slot][t] = observe(0);
      drive(0, 1'b0, 0);
      @(negedge clk);
    end
    exp_rgb[0] = pixel_bits(0, A_C - 1, pl);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   pl;
    bit   saw_complete;

    // Column k holds {6{8'(k)}}: plane 0 is 1 for odd k, plane 7 is 0 for k < 128.
    vecs[0]  = '{plane: 0, t: 1,  exp: mk(1, 0, 1, 0, 0,  8'h00)};
    vecs[1]  = '{plane: 0, t: 2,  exp: mk(1, 0, 1, 0, 1,  8'h00)};
    vecs[2]  = '{plane: 0, t: 3,  exp: mk(0, 0, 1, 0, 2,  8'h3f)};
    vecs[3]  = '{plane: 0, t: 4,  exp: mk(1, 1, 1, 0, 2,  8'h3f)};
    vecs[4]  = '{plane: 0, t: 5,  exp: mk(0, 0, 1, 0, 3,  8'h00)};
    vecs[5]  = '{plane: 0, t: 6,  exp: mk(1, 1, 1, 0, 3,  8'h00)};
    vecs[6]  = '{plane: 0, t: 7,  exp: mk(0, 0, 1, 0, 4,  8'h3f)};
    vecs[7]  = '{plane: 0, t: 66, exp: mk(1, 1, 1, 0, 31, 8'h3f)};
    vecs[8]  = '{plane: 0, t: 67, exp: mk(0, 0, 0, 1, 0,  8'h3f)};
    vecs[9]  = '{plane: 0, t: 68, exp: mk(0, 0, 0, 0, 0,  8'h3f)};
    vecs[10] = '{plane: 7, t: 1,  exp: mk(1, 0, 1, 0, 0,  8'h3f)};
    vecs[11] = '{plane: 7, t: 3,  exp: mk(0, 0, 1, 0, 2,  8'h00)};
    vecs[12] = '{plane: 7, t: 67, exp: mk(0, 0, 0, 1, 0,  8'h00)};

    for (int k = 0; k < A_C; k++) mem_a[k] = {6{8'(k)}};
    randomize_mem(1);
    exp_rgb[0] = '0;
    exp_rgb[1] = '0;

    drive(0, 1'b1, 3);
    repeat (2) @(negedge clk);
    check("reset A", observe(0), mk(0, 0, 0, 0, 0, 8'h00));
    check("reset B", observe(1), mk(0, 0, 0, 0, 0, 8'h00));
    drive(0, 1'b0, 0);
    rst = 1'b1;
    @(negedge clk);
    check("idle A", observe(0), mk(0, 0, 0, 0, 0, 8'h00));
    check("idle B", observe(1), mk(0, 0, 0, 0, 0, 8'h00));

    log_row_a(0, 0);
    log_row_a(7, 1);
    for (int v = 0; v < 13; v++) begin
      check($sformatf("vec%0d plane=%0d t=%0d", v, vecs[v].plane, vecs[v].t),
            log_a[vecs[v].plane == 7][vecs[v].t], vecs[v].exp);
    end

    repeat (4) begin
      randomize_mem(0);
      run_row(0, int'($urandom_range(0, 7)), 1'b0, 1'b0, 0, 1'b1, "randA");
    end
    repeat (4) begin
      randomize_mem(1);
      run_row(1, int'($urandom_range(0, 7)), 1'b0, 1'b0, 0, 1'b1, "randB");
    end
    randomize_mem(1);
    run_row(1, 7, 1'b0, 1'b0, 0, 1'b0, "B plane7");

    randomize_mem(0);
    pl = int'($urandom_range(0, 7));
    run_row(0, 2, 1'b0, 1'b1, pl, 1'b1, "b2bA row1");
    run_row(0, pl, 1'b1, 1'b0, 0, 1'b1, "b2bA row2");
    randomize_mem(1);
    run_row(1, 4, 1'b0, 1'b1, 1, 1'b1, "b2bB row1");
    run_row(1, 1, 1'b1, 1'b0, 0, 1'b1, "b2bB row2");

    // Reset in the middle of a row on A.
    randomize_mem(0);
    drive(0, 1'b1, 5);
    @(negedge clk);
    drive(0, 1'b0, 0);
    saw_complete = 1'b0;
    for (n = 0; n < 40; n++) begin
      if (col_a == 5'd10) break;
      saw_complete |= comp_a;
      @(negedge clk);
    end
    check_int("rst reach column 10", n < 40, 1);
    check_int("rst no complete before", int'(saw_complete), 0);
    rst = 1'b0;
    drive(0, 1'b1, 6);
    @(negedge clk);
    exp_rgb[0] = '0;
    exp_rgb[1] = '0;
    check("rst midrow A", observe(0), mk(0, 0, 0, 0, 0, 8'h00));
    check("rst midrow B", observe(1), mk(0, 0, 0, 0, 0, 8'h00));
    @(negedge clk);
    check("rst load ignored", observe(0), mk(0, 0, 0, 0, 0, 8'h00));
    rst = 1'b1;
    drive(0, 1'b0, 0);
    @(negedge clk);
    check("rst released idle", observe(0), mk(0, 0, 0, 0, 0, 8'h00));
    run_row(0, int'($urandom_range(0, 7)), 1'b0, 1'b0, 0, 1'b0, "after rst");

`ifdef DISPLAY_ROW_SHIFTER_ABORT_EN
    randomize_mem(0);
    pl = int'($urandom_range(0, 7));
    drive(0, 1'b1, pl);
    @(negedge clk);
    drive(0, 1'b0, 0);
    repeat (3) @(negedge clk);
    check_int("abort oclk high before", int'(oclk_a), 1);
    abort_a = 1'b1;
    drive(0, 1'b1, 0);
    @(negedge clk);
    exp_rgb[0] = pixel_bits(0, 1, pl);
    check("abort in HIGH", observe(0), mk(0, 0, 0, 0, 0, exp_rgb[0]));
    @(negedge clk);
    check("abort beats load", observe(0), mk(0, 0, 0, 0, 0, exp_rgb[0]));
    abort_a = 1'b0;
    drive(0, 1'b0, 0);
    @(negedge clk);
    check("after abort idle", observe(0), mk(0, 0, 0, 0, 0, exp_rgb[0]));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/display_row_shifter.md
DISPLAY_ROW_SHIFTER -- requirements
Module: display_row_shifter

Interface
REQ-001 SHALL have parameter PIPE_LENGTH, default 2: fetch-pipeline depth in pipe pulses (>=1).
REQ-002 SHALL have parameter COLUMNS, default 32: columns shifted per row (>=2).
REQ-003 SHALL have parameter BITWIDTH, default 8: bits per colour component.
REQ-004 SHALL have parameter CHAINS, default 2: parallel panel chains, 3 components (R,G,B) each.
REQ-005 SHALL have parameter CLK_DIV, default 1: cycles per oclk low phase and per oclk high phase (>=1).
REQ-006 SHALL have ports: clk  in  1  sole clock; rst  in  1  synchronous active-low reset.
REQ-007 SHALL have ports: load  in  1  start row; plane  in  $clog2(BITWIDTH)  bit-plane index.
REQ-008 SHALL have ports: data_in  in  CHAINS*3*BITWIDTH  fetched pixel data, chain-major, R,G,B within a chain.
REQ-009 SHALL have ports: column  out  $clog2(COLUMNS)  fetch address; pipe  out  1  fetch-pipeline advance.
REQ-010 SHALL have ports: oclk  out  1  panel shift clock; rgb  out  CHAINS*3  selected-plane bits; busy  out  1; complete  out  1.

Function
REQ-011 SHALL implement states IDLE, FILL, LOW, HIGH, DONE.
REQ-012 IDLE: load=1 SHALL move to FILL next cycle and latch plane; load=0 SHALL hold IDLE.
REQ-013 FILL SHALL last PIPE_LENGTH cycles with pipe=1, oclk=0, then move to LOW.
REQ-014 LOW SHALL last CLK_DIV cycles with pipe=0, oclk=0; HIGH SHALL last CLK_DIV cycles with oclk=1, pipe=1 on the first HIGH cycle only.
REQ-015 rgb SHALL be registered from data_in at the clock edge entering each LOW, bit [plane] of every component.
REQ-016 A latched plane >= BITWIDTH SHALL yield rgb all zero.
REQ-017 column SHALL increment the cycle after each pipe=1 cycle while below COLUMNS-1, then hold COLUMNS-1.
REQ-018 Exactly COLUMNS LOW/HIGH pairs SHALL occur per row; after the last HIGH the state SHALL be DONE.
REQ-019 DONE SHALL last one cycle: complete=1, column=0, oclk=0, pipe=0, busy=0.
REQ-020 busy SHALL be 1 in FILL, LOW, HIGH; load during those states SHALL be ignored.
REQ-021 load=1 in DONE SHALL be accepted (DONE->FILL), giving back-to-back rows.
REQ-022 rgb SHALL hold its value outside LOW-entry edges, including in DONE and IDLE.

Reset
REQ-023 rst=0 at a clock edge SHALL force IDLE, column=0, pipe=0, oclk=0, rgb=0, busy=0, complete=0, latched plane=0.
REQ-024 rst=0 mid-row SHALL abort immediately without asserting complete; load is ignored while rst=0.

Configuration
REQ-025 With DISPLAY_ROW_SHIFTER_ABORT_EN defined, an input abort (1 bit) SHALL exist; abort=1 in any non-IDLE state SHALL give IDLE next cycle with reset output values except rgb held, no complete.
REQ-026 abort=1 with load=1 in IDLE or DONE SHALL take priority (stay/enter IDLE).
REQ-027 Without DISPLAY_ROW_SHIFTER_ABORT_EN the abort port and logic SHALL be absent.

Structure
REQ-028 State encoding enum and a row_shifter_state_t typedef SHALL live in shared package display_pkg.
REQ-029 Plane selection and rgb register SHALL be sub-module display_plane_select (params CHAINS, BITWIDTH).

Verification
REQ-030 PIPE_LENGTH=2, COLUMNS=32, CLK_DIV=1, load 1 cycle -> cycles 1-2 pipe=1 column 0,1; cycle 3 LOW pipe=0 column 2; cycle 4 HIGH oclk=1 pipe=1; complete at cycle 67, column=0.
REQ-031 CLK_DIV=3, COLUMNS=4 -> each oclk low 3 cycles, high 3 cycles, pipe one cycle per HIGH, 4 oclk pulses, complete once.
REQ-032 CHAINS=2, data_in column k = {6{8'hk}}, plane=0 then plane=7 -> rgb=6'b111111 for odd k, 0 for even k; plane=7 -> 0 for k<128.
REQ-033 load held high through DONE -> second row starts next cycle; load pulses during busy -> no effect.
REQ-034 rst=0 at column 10 -> next cycle all outputs reset, no complete; subsequent load restarts at column 0.
REQ-035 With DISPLAY_ROW_SHIFTER_ABORT_EN, abort in HIGH -> IDLE next cycle, oclk=0, complete never asserted.
